// File: rtl/dcache_wbuf.sv
// Write buffer between the data cache and the memory bridge: stores drain in order, line refills
// wait until the buffer is empty. Define DCACHE_WBUF_MERGE_EN to merge stores into the tail entry.
module dcache_wbuf #(
    parameter int unsigned depth        = 4,
    parameter int unsigned offset_width = 2,
    localparam int unsigned LW          = 32 * (2 << offset_width)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          dcache_wbuf_req,
    input  logic          dcache_wbuf_wr,
    input  logic [31:0]   dcache_wbuf_addr,
    input  logic [31:0]   dcache_wbuf_data,
    input  logic [1:0]    dcache_wbuf_size,
    input  logic [3:0]    dcache_wbuf_wstrb,
    output logic          wbuf_dcache_addrOK,
    output logic          wbuf_dcache_dataOK,
    output logic [LW-1:0] wbuf_dcache_rdata,
    output logic          wbuf_mem_req,
    output logic          wbuf_mem_wr,
    output logic [31:0]   wbuf_mem_addr,
    output logic [31:0]   wbuf_mem_data,
    output logic [1:0]    wbuf_mem_size,
    output logic [3:0]    wbuf_mem_wstrb,
    input  logic          mem_wbuf_addrOK,
    input  logic          mem_wbuf_dataOK,
    input  logic [LW-1:0] mem_wbuf_rdata,
    output logic          wbuf_empty
);
    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [3:0]  wstrb;
    } entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdData,
        StRdResp
    } state_e;

    state_e        r_state;
    entry_t        r_fifo [depth];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_rd_addr;
    logic [LW-1:0] r_rdata;
    logic          r_wr_ack;

    logic [PW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_rd_busy;
    logic          w_merge;
    logic          w_wr_accept;
    logic          w_rd_accept;
    logic          w_push;
    logic          w_pop;
    entry_t        w_head;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == PW'(depth));
    assign w_empty   = (w_count == '0);
    assign w_rd_busy = (r_state inside {StRdAddr, StRdData, StRdResp});
    assign w_head    = r_fifo[r_rd_ptr[AW-1:0]];

`ifdef DCACHE_WBUF_MERGE_EN
    logic [AW-1:0] w_tail_idx;
    entry_t        w_tail;
    entry_t        w_merged;

    assign w_tail_idx = r_wr_ptr[AW-1:0] - AW'(1);
    assign w_tail     = r_fifo[w_tail_idx];
    // A lone entry that is already on the memory bus must not change under the bridge.
    assign w_merge    = !w_empty && (w_tail.addr[31:2] == dcache_wbuf_addr[31:2]) &&
                        !((w_count == PW'(1)) && (r_state inside {StWrAddr, StWrData}));

    always_comb begin
        w_merged       = w_tail;
        w_merged.size  = 2'd2;
        w_merged.wstrb = w_tail.wstrb | dcache_wbuf_wstrb;
        w_merged.data  = {dcache_wbuf_wstrb[3] ? dcache_wbuf_data[31:24] : w_tail.data[31:24],
                          dcache_wbuf_wstrb[2] ? dcache_wbuf_data[23:16] : w_tail.data[23:16],
                          dcache_wbuf_wstrb[1] ? dcache_wbuf_data[15:8]  : w_tail.data[15:8],
                          dcache_wbuf_wstrb[0] ? dcache_wbuf_data[7:0]   : w_tail.data[7:0]};
    end
`else
    assign w_merge = 1'b0;
`endif

    assign w_wr_accept = dcache_wbuf_req && dcache_wbuf_wr && !w_rd_busy && (!w_full || w_merge);
    assign w_rd_accept = dcache_wbuf_req && !dcache_wbuf_wr && w_empty && (r_state == StIdle);
    assign w_push      = w_wr_accept && !w_merge;
    assign w_pop       = (r_state == StWrData) && mem_wbuf_dataOK;

    // Gated by rstn so the handshake is quiet while reset is held.
    assign wbuf_dcache_addrOK = rstn && (w_wr_accept || w_rd_accept);
    assign wbuf_dcache_dataOK = r_wr_ack || (r_state == StRdResp);
    assign wbuf_dcache_rdata  = r_rdata;
    assign wbuf_empty         = w_empty && (r_state == StIdle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fifo   <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_wr_ack <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_accept;
            if (w_push) begin
                r_fifo[r_wr_ptr[AW-1:0]] <= {dcache_wbuf_addr, dcache_wbuf_data,
                                             dcache_wbuf_size, dcache_wbuf_wstrb};
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
`ifdef DCACHE_WBUF_MERGE_EN
            else if (w_wr_accept && w_merge) begin
                r_fifo[w_tail_idx] <= w_merged;
            end
`endif
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= StIdle;
            r_rd_addr <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_state <= StWrAddr;
                    end else if (w_rd_accept) begin
                        r_state   <= StRdAddr;
                        r_rd_addr <= dcache_wbuf_addr;
                    end
                end
                StWrAddr: if (mem_wbuf_addrOK) r_state <= StWrData;
                StWrData: begin
                    // Something remains if more than the head was queued or a store lands now.
                    if (mem_wbuf_dataOK) begin
                        r_state <= ((w_count != PW'(1)) || w_push) ? StWrAddr : StIdle;
                    end
                end
                StRdAddr: if (mem_wbuf_addrOK) r_state <= StRdData;
                StRdData: begin
                    if (mem_wbuf_dataOK) begin
                        r_rdata <= mem_wbuf_rdata;
                        r_state <= StRdResp;
                    end
                end
                StRdResp: r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        wbuf_mem_req   = 1'b0;
        wbuf_mem_wr    = 1'b0;
        wbuf_mem_addr  = '0;
        wbuf_mem_data  = '0;
        wbuf_mem_size  = '0;
        wbuf_mem_wstrb = '0;
        case (r_state)
            StWrAddr, StWrData: begin
                wbuf_mem_req   = (r_state == StWrAddr);
                wbuf_mem_wr    = 1'b1;
                wbuf_mem_addr  = w_head.addr;
                wbuf_mem_data  = w_head.data;
                wbuf_mem_size  = w_head.size;
                wbuf_mem_wstrb = w_head.wstrb;
            end
            StRdAddr, StRdData: begin
                wbuf_mem_req  = (r_state == StRdAddr);
                wbuf_mem_addr = r_rd_addr;
                wbuf_mem_size = 2'd2;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dcache_wbuf.md
# dcache_wbuf

Write buffer between the data cache memory port and the memory/bus bridge. Absorbs write-through stores from the cache into a small FIFO so the pipeline does not wait on memory, and drains them to memory one transaction at a time. Line-refill reads from the cache pass through only after all buffered writes have drained, which preserves read-after-write ordering.

## Interface
- depth, 4, number of store entries; power of two, at least 2
- offset_width, 2, line offset width; line width LW = 32*(2<<offset_width)

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- dcache_wbuf_req  in  1  request from cache
- dcache_wbuf_wr  in  1  0 = line read, 1 = word write
- dcache_wbuf_addr  in  32  request address
- dcache_wbuf_data  in  32  write data
- dcache_wbuf_size  in  2  0 = 1B, 1 = 2B, 2 = 4B
- dcache_wbuf_wstrb  in  4  byte enables
- wbuf_dcache_addrOK  out  1  request accepted this cycle
- wbuf_dcache_dataOK  out  1  one-cycle completion pulse
- wbuf_dcache_rdata  out  LW  refill line, valid with dataOK on reads
- wbuf_mem_req, wbuf_mem_wr, wbuf_mem_addr[31:0], wbuf_mem_data[31:0], wbuf_mem_size[1:0], wbuf_mem_wstrb[3:0]  out  memory-side request, same meanings as above
- mem_wbuf_addrOK  in  1  memory accepted request
- mem_wbuf_dataOK  in  1  memory completed transaction
- mem_wbuf_rdata  in  LW  refill line from memory
- wbuf_empty  out  1  FIFO empty and no memory transaction in flight

## Operation
- FIFO entry holds {addr, data, size, wstrb}. Pointers are log2(depth)+1 bits wide so full and empty are distinguishable; pointers wrap naturally.
- Write accept: req & wr & !full gives addrOK high combinationally in the same cycle, the entry is pushed at the edge, and dataOK pulses the next cycle. When full, addrOK stays low and the cache holds req.
- Read accept: req & !wr gives addrOK only when the FIFO is empty and the FSM is IDLE. Otherwise the FSM keeps draining. Reads never bypass buffered writes.
- A new write is never accepted while a read is outstanding, because addrOK is low outside IDLE whenever a read is in progress.
- Drain FSM states:
  - IDLE: go to WR_ADDR if the FIFO is non-empty; go to RD_ADDR if a read was accepted this cycle.
  - WR_ADDR: drive the head entry with req=1, wr=1. Go to WR_DATA on mem_wbuf_addrOK.
  - WR_DATA: on mem_wbuf_dataOK, pop the head and go to WR_ADDR if entries remain, else IDLE.
  - RD_ADDR: drive the latched read address with wr=0, size=2, wstrb=0. Go to RD_DATA on addrOK.
  - RD_DATA: on dataOK, register mem_wbuf_rdata and go to RD_RESP.
  - RD_RESP: drive dataOK=1 with the registered line, then go to IDLE.
- At most one memory transaction is outstanding.
- Push and pop in the same cycle are allowed; the count is unchanged.
- Reset mid-operation clears the FIFO, pointers, FSM (to IDLE) and latched read. Buffered stores are lost.
- Reset values: every output is 0, except wbuf_empty=1.

## Timing
- Write latency to the cache: addrOK in cycle 0, dataOK in cycle 1.
- A pushed entry is issued to memory no earlier than the cycle after the push (wbuf_mem_req rises at cycle 1 at the earliest).
- Read latency: addrOK in cycle 0, wbuf_mem_req in cycle 1, and wbuf_dcache_dataOK exactly one cycle after mem_wbuf_dataOK.
- Memory-side request signals stay stable while req=1 and addrOK=0.

## Configuration
- DCACHE_WBUF_MERGE_EN defined: a write whose addr[31:2] matches the tail (most recently pushed) entry, where that entry is not the head currently issued in WR_ADDR/WR_DATA, merges into it:
  - bytes with wstrb set overwrite the stored data;
  - the entry's wstrb becomes the OR of the old and new wstrb;
  - the entry's size becomes 2.
  - There is no push; addrOK and dataOK behave as for a normal write, and merging is accepted even when the FIFO is full.
- DCACHE_WBUF_MERGE_EN undefined: every write occupies its own entry.

## Test plan
- Single store 0x100/0xDEADBEEF/wstrb 4'hF with the memory accepting immediately -> addrOK cycle 0, dataOK cycle 1; one memory write with the same fields; wbuf_empty returns to 1.
- Five stores back-to-back with depth=4 and memory addrOK held low -> the first four are accepted; addrOK stays low for the fifth until the first pop, after which it is accepted.
- Store to 0x200, then a read of 0x200 -> read addrOK waits for the memory write's dataOK; the memory read is issued after it; line returned with dataOK one cycle after mem dataOK.
- Push and pop in the same cycle with count=2 -> count stays 2; FIFO order preserved across pointer wrap.
- rstn low while in WR_DATA -> all outputs 0 immediately, wbuf_empty=1; no stale memory request after release.
- With DCACHE_WBUF_MERGE_EN: stores 0x300 wstrb 4'h1 data 0x000000AA, then 0x300 wstrb 4'h4 data 0x00CC0000, while the memory is stalled -> single entry, data 0x00CC00AA, wstrb 4'h5, size 2.
